// File: rtl/wavelet_db2_analysis.sv
// Single-level Daubechies-2 (4-tap) analysis filter bank.
// Splits a signed ADC stream into approximation (low) and detail (high) bands at full input
// rate; the ÷2 downsamplers sit downstream. Pipeline: delay line -> products -> sums ->
// round/reduce/output, three registered stages after the capture edge.
// Build option: define WAVELET_DB2_SAT_EN to clamp results to the ADC range; otherwise
// results wrap (two's-complement truncation).
module wavelet_db2_analysis #(
  parameter int ADC_WIDTH  = 14,
  parameter int COEF_WIDTH = 16,
  parameter int H0         = 15826,
  parameter int H1         = 27411,
  parameter int H2         = 7345,
  parameter int H3         = -4240
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [ADC_WIDTH-1:0] adc_data_in,
  input  logic                        adc_valid_in,
  output logic signed [ADC_WIDTH-1:0] low_data_out,
  output logic signed [ADC_WIDTH-1:0] high_data_out,
  output logic                        data_valid_out
);

  localparam int PW = ADC_WIDTH + COEF_WIDTH;  // product width
  localparam int SW = PW + 2;                  // 4-input sum width

  // Low-pass taps and their quadrature-mirror high-pass counterparts.
  localparam logic signed [COEF_WIDTH-1:0] C_H0 = COEF_WIDTH'(H0);
  localparam logic signed [COEF_WIDTH-1:0] C_H1 = COEF_WIDTH'(H1);
  localparam logic signed [COEF_WIDTH-1:0] C_H2 = COEF_WIDTH'(H2);
  localparam logic signed [COEF_WIDTH-1:0] C_H3 = COEF_WIDTH'(H3);
  localparam logic signed [COEF_WIDTH-1:0] C_G0 = COEF_WIDTH'(H3);
  localparam logic signed [COEF_WIDTH-1:0] C_G1 = COEF_WIDTH'(-H2);
  localparam logic signed [COEF_WIDTH-1:0] C_G2 = COEF_WIDTH'(H1);
  localparam logic signed [COEF_WIDTH-1:0] C_G3 = COEF_WIDTH'(-H0);

  // Half-LSB of the Q1.(COEF_WIDTH-1) result, added before the floor shift.
  localparam logic signed [SW-1:0] RND = SW'(1) << (COEF_WIDTH - 2);

  // Delay line and fill tracking
  logic signed [ADC_WIDTH-1:0] r_x [4];
  logic        [1:0]           r_fill;
  logic                        w_fill_done;
  logic        [2:0]           r_vpipe;

  // Tap constants as indexable arrays
  logic signed [COEF_WIDTH-1:0] w_ch [4];
  logic signed [COEF_WIDTH-1:0] w_cg [4];

  // Pipeline stages
  logic signed [PW-1:0]        r_plo [4];
  logic signed [PW-1:0]        r_phi [4];
  logic signed [SW-1:0]        r_sum_lo;
  logic signed [SW-1:0]        r_sum_hi;
  logic signed [SW-1:0]        w_rnd_lo;
  logic signed [SW-1:0]        w_rnd_hi;
  logic signed [SW-1:0]        w_shf_lo;
  logic signed [SW-1:0]        w_shf_hi;
  logic signed [ADC_WIDTH-1:0] w_red_lo;
  logic signed [ADC_WIDTH-1:0] w_red_hi;
  logic signed [ADC_WIDTH-1:0] r_low;
  logic signed [ADC_WIDTH-1:0] r_high;
  logic                        r_vout;

  function automatic logic signed [SW-1:0] sx(input logic signed [PW-1:0] p);
    return {{(SW - PW){p[PW-1]}}, p};
  endfunction

  // Constant tap tables
  always_comb begin
    w_ch[0] = C_H0;
    w_ch[1] = C_H1;
    w_ch[2] = C_H2;
    w_ch[3] = C_H3;
    w_cg[0] = C_G0;
    w_cg[1] = C_G1;
    w_cg[2] = C_G2;
    w_cg[3] = C_G3;
  end

  // A capture completes the window once three earlier samples are already held.
  assign w_fill_done = adc_valid_in && (r_fill == 2'd3);

  // Delay line: shift in a new sample on each captured edge, hold otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) r_x[i] <= '0;
    end else if (adc_valid_in) begin
      r_x[0] <= adc_data_in;
      for (int i = 1; i < 4; i++) r_x[i] <= r_x[i-1];
    end
  end

  // Saturating fill counter: suppresses strobes until the window holds real samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fill <= 2'd0;
    end else if (adc_valid_in && (r_fill != 2'd3)) begin
      r_fill <= r_fill + 2'd1;
    end
  end

  // Valid pipe tracks each full window through the product and sum stages
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vpipe <= 3'b000;
    end else begin
      r_vpipe <= {r_vpipe[1:0], w_fill_done};
    end
  end

  // S1: eight signed products, free-running
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        r_plo[i] <= '0;
        r_phi[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        r_plo[i] <= r_x[i] * w_ch[i];
        r_phi[i] <= r_x[i] * w_cg[i];
      end
    end
  end

  // S2: per-band 4-input sums with two guard bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum_lo <= '0;
      r_sum_hi <= '0;
    end else begin
      r_sum_lo <= sx(r_plo[0]) + sx(r_plo[1]) + sx(r_plo[2]) + sx(r_plo[3]);
      r_sum_hi <= sx(r_phi[0]) + sx(r_phi[1]) + sx(r_phi[2]) + sx(r_phi[3]);
    end
  end

  // S3 combinational part: round half-up, then drop the fractional bits
  always_comb begin
    w_rnd_lo = r_sum_lo + RND;
    w_rnd_hi = r_sum_hi + RND;
    w_shf_lo = w_rnd_lo >>> (COEF_WIDTH - 1);
    w_shf_hi = w_rnd_hi >>> (COEF_WIDTH - 1);
  end

`ifdef WAVELET_DB2_SAT_EN
  localparam logic signed [SW-1:0] LIM_MAX = SW'((2 ** (ADC_WIDTH - 1)) - 1);
  localparam logic signed [SW-1:0] LIM_MIN = SW'(-(2 ** (ADC_WIDTH - 1)));
  localparam logic signed [ADC_WIDTH-1:0] OUT_MAX = {1'b0, {(ADC_WIDTH - 1){1'b1}}};
  localparam logic signed [ADC_WIDTH-1:0] OUT_MIN = {1'b1, {(ADC_WIDTH - 1){1'b0}}};

  // Clamp to the ADC range; low-band DC gain of ~1.414 can exceed it
  always_comb begin
    w_red_lo = w_shf_lo[ADC_WIDTH-1:0];
    w_red_hi = w_shf_hi[ADC_WIDTH-1:0];
    if (w_shf_lo > LIM_MAX) begin
      w_red_lo = OUT_MAX;
    end else if (w_shf_lo < LIM_MIN) begin
      w_red_lo = OUT_MIN;
    end
    if (w_shf_hi > LIM_MAX) begin
      w_red_hi = OUT_MAX;
    end else if (w_shf_hi < LIM_MIN) begin
      w_red_hi = OUT_MIN;
    end
  end
`else
  logic w_unused;

  // Wrap: keep only the low ADC_WIDTH bits
  always_comb begin
    w_red_lo = w_shf_lo[ADC_WIDTH-1:0];
    w_red_hi = w_shf_hi[ADC_WIDTH-1:0];
    w_unused = ^{w_shf_lo[SW-1:ADC_WIDTH], w_shf_hi[SW-1:ADC_WIDTH]};
  end
`endif

  // S3 register: load only for a full window so outputs hold across gaps and fill
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_low  <= '0;
      r_high <= '0;
      r_vout <= 1'b0;
    end else begin
      r_vout <= r_vpipe[2];
      if (r_vpipe[2]) begin
        r_low  <= w_red_lo;
        r_high <= w_red_hi;
      end
    end
  end

  assign low_data_out   = r_low;
  assign high_data_out  = r_high;
  assign data_valid_out = r_vout;

endmodule

// File: tb/tb_wavelet_db2_analysis.sv
// Scoreboard bench for wavelet_db2_analysis: stimulus pushes hand-computed expected pairs,
// a negedge monitor pops them on each strobe and checks values, latency and output hold.
module tb_wavelet_db2_analysis;

  typedef struct {
    int lo;
    int hi;
    int cap;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic signed [13:0] adc_data_in = '0;
  logic              adc_valid_in = 1'b0;
  logic signed [13:0] low_data_out;
  logic signed [13:0] high_data_out;
  logic              data_valid_out;

  exp_t q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   n_strobe = 0;
  int   last_lo  = 0;
  int   last_hi  = 0;

  wavelet_db2_analysis dut (
    .clk           (clk),
    .rst           (rst),
    .adc_data_in   (adc_data_in),
    .adc_valid_in  (adc_valid_in),
    .low_data_out  (low_data_out),
    .high_data_out (high_data_out),
    .data_valid_out(data_valid_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every strobe must match the oldest expectation; idle cycles must hold.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      last_lo = 0;
      last_hi = 0;
    end else if (data_valid_out) begin
      n_strobe++;
      if (q.size() == 0) begin
        chk("unexpected_strobe", 1, 0);
      end else begin
        e = q.pop_front();
        chk("low", int'(low_data_out), e.lo);
        chk("high", int'(high_data_out), e.hi);
        chk("latency", cyc - e.cap, 3);
      end
      last_lo = int'(low_data_out);
      last_hi = int'(high_data_out);
    end else begin
      chk("hold_low", int'(low_data_out), last_lo);
      chk("hold_high", int'(high_data_out), last_hi);
    end
  end

  // Present one sample for one edge; push its expected pair if it completes a window.
  task automatic send(input int d, input bit exp_v, input int lo, input int hi);
    @(posedge clk);
    #1;
    adc_data_in  = 14'(d);
    adc_valid_in = 1'b1;
    if (exp_v) q.push_back('{lo: lo, hi: hi, cap: cyc + 1});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      adc_valid_in = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst          = 1'b1;
    adc_valid_in = 1'b0;
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b0;
    n_strobe = 0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
    chk(name, q.size(), 0);
    idle(3);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_low", int'(low_data_out), 0);
    chk("rst_high", int'(high_data_out), 0);
    chk("rst_valid", int'(data_valid_out), 0);
    rst = 1'b0;

    // Impulse, back-to-back
    send(0, 0, 0, 0);
    send(0, 0, 0, 0);
    send(0, 0, 0, 0);
    send(1000, 1, 483, -129);
    send(0, 1, 837, -224);
    send(0, 1, 224, 837);
    send(0, 1, -129, -483);
    idle(1);
    drain("impulse_drain");
    chk("impulse_strobes", n_strobe, 4);

    // Impulse with valid every third cycle: same values, outputs hold between strobes
    do_reset();
    send(0, 0, 0, 0);    idle(2);
    send(0, 0, 0, 0);    idle(2);
    send(0, 0, 0, 0);    idle(2);
    send(1000, 1, 483, -129); idle(2);
    send(0, 1, 837, -224);    idle(2);
    send(0, 1, 224, 837);     idle(2);
    send(0, 1, -129, -483);   idle(2);
    drain("gap_drain");
    chk("gap_strobes", n_strobe, 4);

    // Fill suppression: three samples give nothing, the fourth strobes
    do_reset();
    for (int i = 0; i < 3; i++) send(1000, 0, 0, 0);
    idle(6);
    chk("fill_no_strobe", n_strobe, 0);
    send(1000, 1, 1414, 0);
    idle(1);
    drain("fill_drain");
    chk("fill_strobes", n_strobe, 1);

    // DC mid-range
    do_reset();
    for (int i = 0; i < 8; i++) send(4000, i >= 3, 5657, 0);
    idle(1);
    drain("dc4000_drain");

    // DC overflow
    do_reset();
`ifdef WAVELET_DB2_SAT_EN
    for (int i = 0; i < 6; i++) send(8000, i >= 3, 8191, 0);
`else
    for (int i = 0; i < 6; i++) send(8000, i >= 3, -5070, 0);
`endif
    idle(1);
    drain("dc8000_drain");

    // Negative full scale
    do_reset();
`ifdef WAVELET_DB2_SAT_EN
    for (int i = 0; i < 6; i++) send(-8192, i >= 3, -8192, 0);
`else
    for (int i = 0; i < 6; i++) send(-8192, i >= 3, 4799, 0);
`endif
    idle(1);
    drain("dcneg_drain");

    // Mid-stream reset, one cycle after the 8th capture of a continuous stream
    do_reset();
    for (int i = 0; i < 8; i++) send(4000, i >= 3, 5657, 0);
    @(posedge clk);
    #1;
    chk("pre_rst_valid", int'(data_valid_out), 1);
    chk("pre_rst_low", int'(low_data_out), 5657);
    rst          = 1'b1;
    adc_valid_in = 1'b0;
    q.delete();
    #1;
    chk("midrst_low", int'(low_data_out), 0);
    chk("midrst_high", int'(high_data_out), 0);
    chk("midrst_valid", int'(data_valid_out), 0);
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b0;
    n_strobe = 0;
    for (int i = 0; i < 3; i++) send(4000, 0, 0, 0);
    idle(5);
    chk("midrst_no_strobe", n_strobe, 0);
    send(4000, 1, 5657, 0);
    send(4000, 1, 5657, 0);
    idle(1);
    drain("midrst_drain");
    chk("midrst_strobes", n_strobe, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global bound on run time
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
